// File: rtl/cond_sum_subtractor_seq.sv
// cond_sum_subtractor_seq
//   Iterative subtractor: diff = a - b - bin (mod 2^WIDTH), one CHUNK-bit
//   slice per clock, LSB slice first. Each slice precomputes its result for
//   borrow-in 0 and borrow-in 1 (conditional-sum style). The borrow registered
//   from the previous slice picks one of the two.
//
// Parameters
//   WIDTH  operand/result width, integer multiple of CHUNK
//   CHUNK  bits per cycle, 2..WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present          in_ready   block can accept operands
//   a, b       minuend / subtrahend      bin        borrow in
//   out_valid  result valid              out_ready  consumer accepts result
//   diff       (a - b - bin) mod 2^WIDTH bout       1 iff a < b + bin
//   busy       operation in progress (RUN or DONE)
//   zero, ovf  result-is-zero / signed overflow flags (only with CSS_FLAGS_EN)
//
// Optional feature macro: CSS_FLAGS_EN adds the zero and ovf outputs.

module cond_sum_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef CSS_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BASE_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((CHUNK < 2) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("cond_sum_subtractor_seq: CHUNK must be 2..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]  a_r, b_r;
  logic              brw;
  logic [IDX_W-1:0]  idx;
  logic [BASE_W-1:0] base;
  logic [CHUNK-1:0]  a_s, b_s;
  logic [CHUNK:0]    r0, r1;
  logic [CHUNK-1:0]  d_sel;
  logic              bo_sel;
  logic              accept;
  logic              last_slice;

  // {borrow, difference} of one slice; the top bit is set exactly when
  // x < y + bi, because the extended result goes negative.
  function automatic logic [CHUNK:0] slice_sub(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             bi);
    slice_sub = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
  endfunction

  // Slice select and both conditional candidates
  always_comb begin
    base       = BASE_W'(idx * CHUNK);
    a_s        = a_r[base +: CHUNK];
    b_s        = b_r[base +: CHUNK];
    r0         = slice_sub(a_s, b_s, 1'b0);
    r1         = slice_sub(a_s, b_s, 1'b1);
    {bo_sel, d_sel} = brw ? r1 : r0;
    accept     = in_valid && (state == IDLE);
    last_slice = (idx == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture; only read while RUN, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Slice result write-back, running borrow and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brw  <= 1'b0;
      idx  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef CSS_FLAGS_EN
      zero <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            brw  <= bin;
            idx  <= '0;
            diff <= '0;
          end
        end
        RUN: begin
          diff[base +: CHUNK] <= d_sel;
          brw                 <= bo_sel;
          idx                 <= idx + 1'b1;
          if (last_slice) begin
            bout <= bo_sel;
`ifdef CSS_FLAGS_EN
            // Lower slices are already in diff and the top slice is still
            // zero, so the final result is zero iff both parts are zero.
            zero <= (diff == '0) && (d_sel == '0);
            ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_sel[CHUNK-1] != a_r[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
